sync_fifo_sched: RTL and testbench

Controller that shares one sync_fifo_cnt instance between two write requesters and schedules reads from it in fixed-length bursts.
- Write side: round-robin arbiter with valid/ready handshakes, driving the FIFO's wr_en and buf_in.
- Read side: an FSM that watches fifo_cnt and issues BURST_LEN back-to-back rd_en pulses when enough data is present and the consumer allows.
- Sits directly between the producers/consumer and the FIFO; the FIFO is instantiated alongside it, not inside it.

---
 rtl/sync_fifo_sched.sv | 146 ++++++++++++++
 tb/tb_sync_fifo_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_sched.sv
// Write-side round-robin arbiter and read-side burst scheduler for one shared sync FIFO.
// The FIFO itself is instantiated next to this block; only its control/status pins come here.
module sync_fifo_sched #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_DEPTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req0_valid,
    input  logic [DATA_WIDTH-1:0]         req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [DATA_WIDTH-1:0]         req1_data,
    output logic                          req1_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    input  logic [$clog2(DATA_DEPTH):0]   fifo_cnt,
    output logic                          fifo_rd_en,
    input  logic                          rd_allow,
    output logic                          dout_valid,
    output logic                          burst_busy,
    output logic                          burst_done
);

    localparam int unsigned CntW  = $clog2(DATA_DEPTH) + 1;
    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CntW-1:0]  BurstLenCnt = CntW'(BURST_LEN);
    localparam logic [BeatW-1:0] LastBeat    = BeatW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StGap
    } rd_state_e;

    // ---------------------------------------------------------------------
    // Write arbitration
    // ---------------------------------------------------------------------
    logic last_grant_q, last_grant_d;
    logic elig0, elig1;
    logic grant0, grant1;

    always_comb begin
        // rst_n gates eligibility so nothing is accepted while the FIFO is held in reset
        elig0 = rst_n & req0_valid & ~fifo_full;
        elig1 = rst_n & req1_valid & ~fifo_full;

        // last_grant_q == 1 means requester 1 won most recently
        grant0 = elig0 & (~elig1 | last_grant_q);
        grant1 = elig1 & (~elig0 | ~last_grant_q);

        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    always_comb begin
        req0_ready   = grant0;
        req1_ready   = grant1;
        fifo_wr_en   = grant0 | grant1;
        fifo_wr_data = '0;
        if (grant0) begin
            fifo_wr_data = req0_data;
        end else if (grant1) begin
            fifo_wr_data = req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // ---------------------------------------------------------------------
    // Read burst FSM
    // ---------------------------------------------------------------------
    rd_state_e        state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic             dout_valid_q, dout_valid_d;
    logic             burst_done_q, burst_done_d;
    logic             last_beat;

    assign last_beat = (beat_q == LastBeat);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            StIdle: begin
                beat_d = '0;
                if ((fifo_cnt >= BurstLenCnt) && rd_allow) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (last_beat) begin
                    state_d = StGap;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            // One idle-read cycle lets the registered fifo_cnt reflect the burst
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        fifo_rd_en   = (state_q == StBurst);
        burst_busy   = (state_q != StIdle);
        dout_valid_d = fifo_rd_en;
        burst_done_d = (state_q == StBurst) && last_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            dout_valid_q <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            dout_valid_q <= dout_valid_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_sync_fifo_sched.sv
// Bench for sync_fifo_sched: a small behavioural FIFO stands in for sync_fifo_cnt,
// arbitration is table-driven, bursts and reset are hand-written sequences.
module tb_sync_fifo_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       fifo_full;
    logic [3:0] fifo_cnt;
    logic       fifo_rd_en;
    logic       rd_allow;
    logic       dout_valid, burst_busy, burst_done;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_sched #(
        .DATA_WIDTH(8),
        .DATA_DEPTH(8),
        .BURST_LEN (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_full   (fifo_full),
        .fifo_cnt    (fifo_cnt),
        .fifo_rd_en  (fifo_rd_en),
        .rd_allow    (rd_allow),
        .dout_valid  (dout_valid),
        .burst_busy  (burst_busy),
        .burst_done  (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural depth-8 FIFO with registered buf_out
    logic [7:0] mem [8];
    logic [2:0] wp, rp;
    logic [7:0] buf_out;
    logic       underflow;
    logic       do_wr, do_rd;

    assign fifo_full = (fifo_cnt == 4'd8);
    assign do_wr     = fifo_wr_en && (fifo_cnt != 4'd8);
    assign do_rd     = fifo_rd_en && (fifo_cnt != 4'd0);

    always @(posedge clk) begin
        if (rst_n && do_wr) mem[wp] <= fifo_wr_data;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= 3'd0;
            rp        <= 3'd0;
            fifo_cnt  <= 4'd0;
            buf_out   <= 8'd0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) wp <= wp + 3'd1;
            if (do_rd) begin
                buf_out <= mem[rp];
                rp      <= rp + 3'd1;
            end
            if (fifo_rd_en && fifo_cnt == 4'd0) underflow <= 1'b1;
            case ({do_wr, do_rd})
                2'b10:   fifo_cnt <= fifo_cnt + 4'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 4'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle with fifo_cnt >= 4; raises rd_allow for that cycle only.
    task automatic run_burst(input logic [31:0] words);
        logic [7:0] w;
        rd_allow = 1'b1;
        @(negedge clk);
        check("burst_idle_rd_en", fifo_rd_en, 1'b0);
        next_cycle();
        rd_allow = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("burst_rd_en", fifo_rd_en, (i < 4));
            check("burst_busy", burst_busy, (i < 5));
            check("burst_dout_valid", dout_valid, (i >= 1 && i <= 4));
            check("burst_done", burst_done, (i == 4));
            if (i >= 1 && i <= 4) begin
                w = words[(4 - i) * 8 +: 8];
                check("burst_data", buf_out, w);
            end
            next_cycle();
        end
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic       wen;
        logic [7:0] wd;
    } arb_vec_t;

    arb_vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           v0    d0    v1    d1    r0 r1 wen wd
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 8'h99, 1, 0, 1, 8'h11};
        vecs[1]  = '{1'b0, 8'h98, 1'b1, 8'h21, 0, 1, 1, 8'h21};
        vecs[2]  = '{1'b1, 8'h12, 1'b1, 8'h22, 1, 0, 1, 8'h12};
        vecs[3]  = '{1'b1, 8'h13, 1'b1, 8'h23, 0, 1, 1, 8'h23};
        vecs[4]  = '{1'b1, 8'h14, 1'b1, 8'h24, 1, 0, 1, 8'h14};
        vecs[5]  = '{1'b1, 8'h15, 1'b0, 8'h97, 1, 0, 1, 8'h15};
        vecs[6]  = '{1'b1, 8'h16, 1'b1, 8'h25, 0, 1, 1, 8'h25};
        vecs[7]  = '{1'b0, 8'h33, 1'b0, 8'h44, 0, 0, 0, 8'h00};
        vecs[8]  = '{1'b1, 8'h17, 1'b1, 8'h26, 1, 0, 1, 8'h17};
        vecs[9]  = '{1'b1, 8'h18, 1'b1, 8'h27, 0, 0, 0, 8'h00};
        vecs[10] = '{1'b1, 8'h19, 1'b0, 8'h28, 0, 0, 0, 8'h00};

        // Reset with a requester already valid
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        rd_allow   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_burst_done", burst_done, 1'b0);
        check("rst_burst_busy", burst_busy, 1'b0);
        check("rst_wr_data", fifo_wr_data, 8'h00);
        next_cycle();
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        rd_allow   = 1'b0;

        // Arbitration table: fills the FIFO to full, then checks that full blocks grants
        for (int i = 0; i < 11; i++) begin
            req0_valid = vecs[i].v0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_data  = vecs[i].d1;
            @(negedge clk);
            check($sformatf("arb%0d_req0_ready", i), req0_ready, vecs[i].r0);
            check($sformatf("arb%0d_req1_ready", i), req1_ready, vecs[i].r1);
            check($sformatf("arb%0d_wr_en", i), fifo_wr_en, vecs[i].wen);
            check($sformatf("arb%0d_wr_data", i), fifo_wr_data, vecs[i].wd);
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Full FIFO but rd_allow low: no burst
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gate_allow_rd_en", fifo_rd_en, 1'b0);
            check("gate_allow_busy", burst_busy, 1'b0);
            next_cycle();
        end
        run_burst(32'h11211223);
        run_burst(32'h14152517);
        check("drain_cnt", fifo_cnt, 4'd0);

        // Three words with rd_allow high: below threshold, no burst
        rd_allow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1;
            req0_data  = 8'hA1 + 8'(i);
            @(negedge clk);
            check("fill3_ready", req0_ready, 1'b1);
            check("fill3_rd_en", fifo_rd_en, 1'b0);
            next_cycle();
        end
        req0_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("gate_cnt3_rd_en", fifo_rd_en, 1'b0);
            next_cycle();
        end
        req0_valid = 1'b1;
        req0_data  = 8'hA4;
        @(negedge clk);
        check("fill4_rd_en", fifo_rd_en, 1'b0);
        next_cycle();
        req0_valid = 1'b0;
        run_burst(32'hA1A2A3A4);
        check("a_burst_cnt", fifo_cnt, 4'd0);
        check("a_burst_underflow", underflow, 1'b0);

        // Concurrent writes during a burst, then reset at beat 2
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1'b1;
            req1_data  = 8'hB1 + 8'(i);
            next_cycle();
        end
        rd_allow  = 1'b1;
        req1_data = 8'hC0;
        @(negedge clk);
        check("conc_start_rd_en", fifo_rd_en, 1'b0);
        next_cycle();
        rd_allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req1_data = 8'hC1 + 8'(i);
            @(negedge clk);
            check("conc_rd_en", fifo_rd_en, 1'b1);
            check("conc_wr_en", fifo_wr_en, 1'b1);
            check("conc_req1_ready", req1_ready, 1'b1);
            check("conc_cnt", fifo_cnt, 4'd5);
            if (i < 2) next_cycle();
        end
        check("conc_dout_valid_pre", dout_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", burst_busy, 1'b0);
        check("mrst_rd_en", fifo_rd_en, 1'b0);
        check("mrst_dout_valid", dout_valid, 1'b0);
        check("mrst_burst_done", burst_done, 1'b0);
        check("mrst_req1_ready", req1_ready, 1'b0);
        check("mrst_wr_en", fifo_wr_en, 1'b0);
        next_cycle();
        rst_n      = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", burst_busy, 1'b0);
        check("post_rst_rd_en", fifo_rd_en, 1'b0);
        next_cycle();

        // Round-robin fairness from reset with both requesters always valid
        rd_allow = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req0_valid = 1'b1;
            req0_data  = 8'h50 + 8'(k);
            req1_valid = 1'b1;
            req1_data  = 8'h60 + 8'(k);
            @(negedge clk);
            check($sformatf("rr%0d_req0_ready", k), req0_ready, (k % 2 == 0));
            check($sformatf("rr%0d_req1_ready", k), req1_ready, (k % 2 == 1));
            check($sformatf("rr%0d_wr_data", k), fifo_wr_data,
                  (k % 2 == 0) ? (8'h50 + 8'(k)) : (8'h60 + 8'(k)));
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_underflow", underflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
